// File: rtl/neuron_acc_pkg.sv
// Shared types and defaults for the neuron accumulator register.
package neuron_acc_pkg;

    localparam int unsigned WIDTH_DEF       = 8;
    localparam int unsigned THRESH_DEF      = 128;
    localparam int unsigned REFRACT_CYC_DEF = 4;
    localparam int unsigned LEAK_SHIFT_DEF  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        INTEG   = 2'd1,
        FIRE    = 2'd2,
        REFRACT = 2'd3
    } state_t;

    // clog2(refract+1), floored at 1 so a zero-length refractory still has a legal vector
    function automatic int unsigned cnt_width(input int unsigned refract);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < (refract + 1))
            w++;
        return w;
    endfunction

endpackage

// File: rtl/neuron_acc_reg_if.sv
// Adder-side bus of the neuron: sum/carry input qualified by sum_valid, membrane state out.
interface neuron_acc_reg_if
    import neuron_acc_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
);
    logic [WIDTH-1:0] sum_in;
    logic             cout_in;
    logic             sum_valid;
    logic [WIDTH-1:0] vmem;
    logic             spike;
    logic             busy;
    logic             sat_flag;

    modport master (
        output sum_in, cout_in, sum_valid,
        input  vmem, spike, busy, sat_flag
    );

    modport slave (
        input  sum_in, cout_in, sum_valid,
        output vmem, spike, busy, sat_flag
    );
endinterface

// File: rtl/neuron_acc_reg_refract_cnt.sv
// Refractory down-counter: loaded on FIRE exit, decremented while enabled, flags the last cycle.
module refract_cnt
    import neuron_acc_pkg::*;
#(
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load,
    input  logic [CW-1:0] value,
    input  logic          en,
    output logic          last
);
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rstn)
            cnt <= '0;
        else if (load)
            cnt <= value;
        else if (en && (cnt != '0))
            cnt <= cnt - CW'(1);
    end

    assign last = (cnt == CW'(1));
endmodule

// File: rtl/neuron_acc_reg.sv
// Integrate-and-fire membrane register with refractory period.
// Optional leak in INTEG enabled by defining NEURON_LEAK_EN.
module neuron_acc_reg
    import neuron_acc_pkg::*;
#(
    parameter int unsigned WIDTH       = WIDTH_DEF,
    parameter int unsigned THRESH      = THRESH_DEF,
    parameter int unsigned REFRACT_CYC = REFRACT_CYC_DEF,
    parameter int unsigned LEAK_SHIFT  = LEAK_SHIFT_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    neuron_acc_reg_if.slave   bus
);
    localparam int unsigned CW = cnt_width(REFRACT_CYC);

    state_t           state;
    logic [WIDTH-1:0] vmem;
    logic [WIDTH-1:0] ld_val;
    logic             sat_flag;
    logic             cnt_last;

    // Carry-out saturates rather than wrapping the adder result
    always_comb begin
        ld_val = bus.cout_in ? '1 : bus.sum_in;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            vmem     <= '0;
            sat_flag <= 1'b0;
        end else begin
            case (state)
                IDLE, INTEG: begin
                    if (bus.sum_valid) begin
                        vmem <= ld_val;
                        if (bus.cout_in)
                            sat_flag <= 1'b1;
                        state <= (ld_val >= WIDTH'(THRESH)) ? FIRE : INTEG;
                    end
`ifdef NEURON_LEAK_EN
                    else if (state == INTEG) begin
                        vmem <= vmem - (vmem >> LEAK_SHIFT);
                    end
`endif
                end
                FIRE: begin
                    vmem     <= '0;
                    sat_flag <= 1'b0;
                    state    <= (REFRACT_CYC == 0) ? IDLE : REFRACT;
                end
                REFRACT: begin
                    if (cnt_last)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    refract_cnt #(
        .CW (CW)
    ) u_refract_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .load  (state == FIRE),
        .value (CW'(REFRACT_CYC)),
        .en    (state == REFRACT),
        .last  (cnt_last)
    );

    assign bus.vmem     = vmem;
    assign bus.spike    = (state == FIRE);
    assign bus.busy     = (state == FIRE) || (state == REFRACT);
    assign bus.sat_flag = sat_flag;
endmodule

// File: tb/tb_neuron_acc_reg.sv
// Directed bench for neuron_acc_reg with default parameters (THRESH=128, REFRACT_CYC=4, LEAK_SHIFT=3).
module tb_neuron_acc_reg;
    logic clk;
    logic rstn;
    int unsigned compared;
    int unsigned mismatched;
    int unsigned busy_cnt;
    int unsigned spike_cnt;

    neuron_acc_reg_if #(.WIDTH(8)) bus ();

    neuron_acc_reg #(
        .WIDTH       (8),
        .THRESH      (128),
        .REFRACT_CYC (4),
        .LEAK_SHIFT  (3)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic c, input logic [7:0] s);
        bus.sum_valid = v;
        bus.cout_in   = c;
        bus.sum_in    = s;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;

        // reset with random inputs
        rstn = 1'b0;
        drive(1'b1, 1'($urandom), 8'($urandom));
        tick();
        drive(1'($urandom), 1'($urandom), 8'($urandom));
        tick();
        chk("rst_vmem",  32'(bus.vmem), 32'd0);
        chk("rst_spike", 32'(bus.spike), 32'd0);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_sat",   32'(bus.sat_flag), 32'd0);

        // sub-threshold capture, then crossing
        rstn = 1'b1;
        drive(1'b1, 1'b0, 8'd100);
        tick();
        drive(1'b0, 1'b0, 8'd0);
        chk("cap100_vmem",  32'(bus.vmem), 32'd100);
        chk("cap100_spike", 32'(bus.spike), 32'd0);
        chk("cap100_busy",  32'(bus.busy), 32'd0);
        tick();
        chk("hold100_vmem", 32'(bus.vmem), 32'd100);

        drive(1'b1, 1'b0, 8'd130);
        tick();
        drive(1'b0, 1'b0, 8'd0);
        chk("fire130_vmem",  32'(bus.vmem), 32'd130);
        chk("fire130_spike", 32'(bus.spike), 32'd1);
        busy_cnt  = bus.busy ? 1 : 0;
        spike_cnt = 0;
        tick();
        chk("post_fire_vmem",  32'(bus.vmem), 32'd0);
        chk("post_fire_spike", 32'(bus.spike), 32'd0);
        for (int i = 0; i < 10; i++) begin
            if (bus.busy) busy_cnt++;
            if (bus.spike) spike_cnt++;
            tick();
        end
        chk("busy_cycles", 32'(busy_cnt), 32'd5);
        chk("extra_spikes", 32'(spike_cnt), 32'd0);
        chk("back_idle_busy", 32'(bus.busy), 32'd0);

        // overflow saturates and fires
        drive(1'b1, 1'b1, 8'h05);
        tick();
        drive(1'b0, 1'b0, 8'd0);
        chk("ovf_vmem",  32'(bus.vmem), 32'hFF);
        chk("ovf_sat",   32'(bus.sat_flag), 32'd1);
        chk("ovf_spike", 32'(bus.spike), 32'd1);
        tick();
        chk("ovf_sat_clr", 32'(bus.sat_flag), 32'd0);
        chk("ovf_vmem_clr", 32'(bus.vmem), 32'd0);

        // inputs dropped during REFRACT (counter 4 -> 3 -> 2)
        drive(1'b1, 1'b1, 8'd200);
        tick();
        chk("drop1_vmem",  32'(bus.vmem), 32'd0);
        chk("drop1_spike", 32'(bus.spike), 32'd0);
        chk("drop1_sat",   32'(bus.sat_flag), 32'd0);
        tick();
        chk("drop2_vmem",  32'(bus.vmem), 32'd0);
        chk("drop2_busy",  32'(bus.busy), 32'd1);
        drive(1'b0, 1'b0, 8'd0);
        tick();
        tick();
        chk("drop_end_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("no_buffer_vmem", 32'(bus.vmem), 32'd0);

        // just below threshold
        drive(1'b1, 1'b0, 8'd127);
        tick();
        drive(1'b0, 1'b0, 8'd0);
        chk("t127_vmem",  32'(bus.vmem), 32'd127);
        chk("t127_spike", 32'(bus.spike), 32'd0);

        // exactly threshold, then reset in 2nd REFRACT cycle
        drive(1'b1, 1'b0, 8'd128);
        tick();
        drive(1'b0, 1'b0, 8'd0);
        chk("t128_spike", 32'(bus.spike), 32'd1);
        tick();
        tick();
        chk("mid_refract_busy", 32'(bus.busy), 32'd1);
        rstn = 1'b0;
        drive(1'b1, 1'b0, 8'd150);
        tick();
        rstn = 1'b1;
        drive(1'b0, 1'b0, 8'd0);
        chk("midrst_busy",  32'(bus.busy), 32'd0);
        chk("midrst_vmem",  32'(bus.vmem), 32'd0);
        chk("midrst_spike", 32'(bus.spike), 32'd0);
        drive(1'b1, 1'b0, 8'd128);
        tick();
        drive(1'b0, 1'b0, 8'd0);
        chk("after_rst_spike", 32'(bus.spike), 32'd1);
        for (int i = 0; i < 6; i++) tick();
        chk("after_rst_idle", 32'(bus.busy), 32'd0);

        // leak / hold in INTEG
        drive(1'b1, 1'b0, 8'd64);
        tick();
        drive(1'b0, 1'b0, 8'd0);
        chk("leak_load", 32'(bus.vmem), 32'd64);
        tick();
`ifdef NEURON_LEAK_EN
        chk("leak_step", 32'(bus.vmem), 32'd56);
`else
        chk("leak_step", 32'(bus.vmem), 32'd64);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/neuron_acc_reg.md
NEURON_ACC_REG -- requirements
Module: neuron_acc_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the membrane/adder datapath width in bits.
REQ-002 SHALL have parameter THRESH, default 128, the firing threshold (unsigned, WIDTH bits).
REQ-003 SHALL have parameter REFRACT_CYC, default 4, the refractory length in clock cycles (0 allowed).
REQ-004 SHALL have parameter LEAK_SHIFT, default 3, the leak divisor exponent.
REQ-005 SHALL have port clk, input, 1 bit, the single system clock; all state updates on its rising edge.
REQ-006 SHALL have port rstn, input, 1 bit, the synchronous, active-low reset.
REQ-007 SHALL have port sum_in, input, WIDTH bits, the sum from the upstream 8-bit adder (Sout).
REQ-008 SHALL have port cout_in, input, 1 bit, the adder carry-out; 1 means overflow.
REQ-009 SHALL have port sum_valid, input, 1 bit, which qualifies sum_in/cout_in for one cycle.
REQ-010 SHALL have port vmem, output, WIDTH bits, the registered membrane potential; it also feeds adder operand A.
REQ-011 SHALL have port spike, output, 1 bit, a one-cycle fire pulse.
REQ-012 SHALL have port busy, output, 1 bit, high in FIRE and REFRACT; inputs are dropped while it is high.
REQ-013 SHALL have port sat_flag, output, 1 bit, a sticky overflow indicator.

Function
REQ-014 SHALL implement a Moore FSM with states IDLE, INTEG, FIRE and REFRACT; the reset state is IDLE.
REQ-015 SHALL, in IDLE or INTEG with sum_valid=1, load vmem at the next edge as follows:
- cout_in=0: vmem=sum_in.
- cout_in=1: vmem=all-ones and sat_flag=1.
REQ-016 SHALL move to FIRE on the same edge as a capture whose loaded value is >= THRESH; otherwise the next state is INTEG.
REQ-017 SHALL hold vmem in IDLE and INTEG when sum_valid=0 (subject to REQ-026).
REQ-018 SHALL, in FIRE, set spike=1 for exactly one cycle while vmem still shows the crossing value.
REQ-019 SHALL, on leaving FIRE, clear vmem to 0, clear sat_flag and load the refractory counter with REFRACT_CYC.
REQ-020 SHALL go from FIRE to REFRACT, or directly to IDLE when REFRACT_CYC=0.
REQ-021 SHALL, in REFRACT, decrement the counter every cycle and go to IDLE on the edge where the counter equals 1; busy SHALL be high for exactly REFRACT_CYC+1 cycles per spike.
REQ-022 SHALL ignore sum_valid during FIRE and REFRACT: no capture, no flag change and no buffering.
REQ-023 SHALL treat a capture of exactly THRESH as a crossing, and a value of THRESH-1 as no crossing.
REQ-024 SHALL leave spike=0 in every state other than FIRE.

Reset
REQ-025 SHALL, when rstn=0 is sampled, go next cycle to state=IDLE, vmem=0, spike=0, busy=0, sat_flag=0 and refractory counter=0.
- This applies in any state, including mid-FIRE and mid-REFRACT.
- rstn SHALL take priority over sum_valid.

Configuration
REQ-026 SHALL use macro NEURON_LEAK_EN to control leak:
- Defined: in INTEG with sum_valid=0, vmem <= vmem - (vmem >> LEAK_SHIFT) each cycle; leak never underflows and never triggers FIRE.
- Undefined: vmem holds and no leak logic is synthesized.

Structure
REQ-027 SHALL place in shared package neuron_acc_pkg:
- the state enum type (IDLE/INTEG/FIRE/REFRACT);
- default constants for WIDTH, THRESH, REFRACT_CYC and LEAK_SHIFT;
- the counter-width function clog2(REFRACT_CYC+1).
REQ-028 SHALL implement the refractory down-counter as sub-module refract_cnt (inputs: load, value, en; output: zero/last indication); the FSM and datapath SHALL stay in neuron_acc_reg.

Verification
REQ-029 SHALL verify reset: rstn=0 for 2 cycles with random inputs -> vmem=0, spike=0, busy=0, sat_flag=0.
REQ-030 SHALL verify a threshold crossing (THRESH=128, REFRACT_CYC=4):
- sum_valid with sum_in=100 -> vmem=100, no spike;
- then sum_in=130 -> spike for 1 cycle, then vmem=0, busy high 5 cycles total, then IDLE.
REQ-031 SHALL verify overflow: cout_in=1 with sum_in=0x05 -> vmem=0xFF, sat_flag=1, spike next cycle, sat_flag=0 after FIRE.
REQ-032 SHALL verify drop during refractory: sum_valid with sum_in=200 during REFRACT -> vmem stays 0, no spike, sat_flag unchanged.
REQ-033 SHALL verify reset mid-operation: rstn=0 in the 2nd REFRACT cycle -> IDLE and busy=0 next cycle; a following sum_in=128 capture -> spike.
REQ-034 SHALL verify leak with NEURON_LEAK_EN defined and LEAK_SHIFT=3: vmem=64 and one idle INTEG cycle -> 56; without the macro -> 64.
